// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath: ball FSM states, coordinate
// width, field centre and default play-field bounds.
package pong_pkg;

  localparam int COORD_W = 8;
  localparam logic [COORD_W-1:0] CENTER = 8'd128;

  localparam int FIELD_X_MIN = 16;
  localparam int FIELD_X_MAX = 239;
  localparam int FIELD_Y_MIN = 16;
  localparam int FIELD_Y_MAX = 239;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } state_t;

endpackage

// File: rtl/axis_step.sv
// One-axis stepper: advances a coordinate by step toward hi (dir=1) or lo
// (dir=0), clamping at the limit and flagging a reflection.
module axis_step
  import pong_pkg::*;
(
  input  logic [COORD_W-1:0] pos,
  input  logic               dir,
  input  logic [COORD_W-1:0] step,
  input  logic [COORD_W-1:0] lo,
  input  logic [COORD_W-1:0] hi,
  output logic [COORD_W-1:0] nxt,
  output logic               flip
);

  // 9-bit sums: pos+step cannot wrap, and pos-step <= lo is tested as
  // pos <= lo+step so no subtraction can underflow.
  logic [COORD_W:0] up_sum;
  logic [COORD_W:0] lo_lim;

  assign up_sum = {1'b0, pos} + {1'b0, step};
  assign lo_lim = {1'b0, lo} + {1'b0, step};

  always_comb begin
    nxt  = pos;
    flip = 1'b0;
    if (dir) begin
      if (up_sum >= {1'b0, hi}) begin
        nxt  = hi;
        flip = 1'b1;
      end else begin
        nxt = up_sum[COORD_W-1:0];
      end
    end else begin
      if ({1'b0, pos} <= lo_lim) begin
        nxt  = lo;
        flip = 1'b1;
      end else begin
        nxt = pos - step;
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball physics: owns ball position, steps it once per frame tick, bounces off
// walls and the left paddle, and reports misses and paddle hits.
module ball_motion
  import pong_pkg::*;
#(
  parameter int X_MIN       = FIELD_X_MIN,
  parameter int X_MAX       = FIELD_X_MAX,
  parameter int Y_MIN       = FIELD_Y_MIN,
  parameter int Y_MAX       = FIELD_Y_MAX,
  parameter int PADDLE_X    = 24,
  parameter int PADDLE_HALF = 12,
  parameter int STEP        = 2,
  parameter int MISS_HOLD   = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [COORD_W-1:0] y_p,
  output logic [COORD_W-1:0] x_b,
  output logic [COORD_W-1:0] y_b,
  output logic               miss,
  output logic [7:0]         hits,
  output logic               running
);

  localparam int HOLD_W = (MISS_HOLD < 1) ? 1 : $clog2(MISS_HOLD + 1);
  // The paddle line is the effective left limit; never let it sit below X_MIN.
  localparam int X_LO = (PADDLE_X > X_MIN) ? PADDLE_X : X_MIN;

  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_LO_C  = COORD_W'(X_LO);
  localparam logic [COORD_W-1:0] X_MAX_C = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MIN_C = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_MAX_C = COORD_W'(Y_MAX);
  localparam logic [HOLD_W-1:0]  HOLD_C  = HOLD_W'(MISS_HOLD);

  state_t              state;
  logic                dx;
  logic                dy;
  logic [HOLD_W-1:0]   hold;
  logic [COORD_W-1:0]  x_nxt;
  logic [COORD_W-1:0]  y_nxt;
  logic                x_flip;
  logic                y_flip;
  logic                at_paddle;
  logic                paddle_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic in_window(input logic [COORD_W-1:0] yb,
                                     input logic [COORD_W-1:0] yp);
    logic signed [COORD_W+1:0] d;
    d = $signed({2'b00, yb}) - $signed({2'b00, yp});
    if (d < 0) d = -d;
    return d <= $signed((COORD_W+2)'(PADDLE_HALF));
  endfunction

  axis_step u_x_step (
    .pos  (x_b),
    .dir  (dx),
    .step (STEP_C),
    .lo   (X_LO_C),
    .hi   (X_MAX_C),
    .nxt  (x_nxt),
    .flip (x_flip)
  );

  axis_step u_y_step (
    .pos  (y_b),
    .dir  (dy),
    .step (STEP_C),
    .lo   (Y_MIN_C),
    .hi   (Y_MAX_C),
    .nxt  (y_nxt),
    .flip (y_flip)
  );

  // A left-moving lower clamp means the ball reached the paddle line.
  assign at_paddle  = !dx && x_flip;
  assign paddle_hit = in_window(y_b, y_p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x_b     <= CENTER;
      y_b     <= CENTER;
      dx      <= 1'b1;
      dy      <= 1'b1;
      hits    <= 8'd0;
      miss    <= 1'b0;
      running <= 1'b0;
      hold    <= '0;
    end else begin
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (at_paddle && !paddle_hit) begin
              miss    <= 1'b1;
              running <= 1'b0;
              state   <= MISS;
              hold    <= HOLD_C;
            end else begin
              x_b <= x_nxt;
              y_b <= y_nxt;
              if (x_flip) dx <= ~dx;
              if (y_flip) dy <= ~dy;
              if (at_paddle) hits <= sat_inc(hits);
            end
          end
        end
        MISS: begin
          if (tick) begin
            hold <= hold - HOLD_W'(1);
            if (hold <= HOLD_W'(1)) begin
              state <= IDLE;
              x_b   <= CENTER;
              y_b   <= CENTER;
              dx    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Scenario bench for ball_motion: a behavioural model predicts each tick's
// outcome into a scoreboard that is compared once the DUT has updated.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] y_p = 8'd128;
  logic [7:0] x_b;
  logic [7:0] y_b;
  logic       miss;
  logic [7:0] hits;
  logic       running;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int x;
    int y;
    int hits;
    bit miss;
    bit running;
  } exp_t;

  exp_t sb[$];

  // model state: mst 0=idle 1=run 2=miss
  int mx, my, mhits, mhold, mst;
  bit mdx, mdy, mmiss;

  ball_motion dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .start   (start),
    .y_p     (y_p),
    .x_b     (x_b),
    .y_b     (y_b),
    .miss    (miss),
    .hits    (hits),
    .running (running)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mx = 128; my = 128; mdx = 1; mdy = 1; mhits = 0; mst = 0; mhold = 0; mmiss = 0;
  endtask

  task automatic model_tick(input int yp);
    int nx, ny, d;
    bit fx, fy;
    mmiss = 0;
    if (mst == 1) begin
      if (mdy) begin
        if (my + 2 >= 239) begin ny = 239; fy = 1; end
        else begin ny = my + 2; fy = 0; end
      end else begin
        if (my - 2 <= 16) begin ny = 16; fy = 1; end
        else begin ny = my - 2; fy = 0; end
      end
      d = my - yp;
      if (d < 0) d = -d;
      if (mdx) begin
        if (mx + 2 >= 239) begin nx = 239; fx = 1; end
        else begin nx = mx + 2; fx = 0; end
      end else if (mx - 2 > 24) begin
        nx = mx - 2; fx = 0;
      end else if (d <= 12) begin
        nx = 24; fx = 1;
        if (mhits < 255) mhits = mhits + 1;
      end else begin
        mmiss = 1; mst = 2; mhold = 60;
        nx = mx; ny = my; fx = 0; fy = 0;
      end
      mx = nx; my = ny;
      if (fx) mdx = !mdx;
      if (fy) mdy = !mdy;
    end else if (mst == 2) begin
      mhold = mhold - 1;
      if (mhold == 0) begin
        mst = 0; mx = 128; my = 128; mdx = 1;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.x = mx; e.y = my; e.hits = mhits; e.miss = mmiss; e.running = (mst == 1);
    sb.push_back(e);
  endtask

  // One tick pulse followed by a quiet cycle; outputs checked after update.
  task automatic do_tick();
    exp_t e;
    model_tick(int'(y_p));
    push_expect();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    e = sb.pop_front();
    tests++;
    if (x_b !== 8'(e.x) || y_b !== 8'(e.y)) begin
      fails++;
      $display("FAIL tick_pos: got (%0d,%0d) expected (%0d,%0d)", x_b, y_b, e.x, e.y);
    end
    tests++;
    if (hits !== 8'(e.hits) || miss !== e.miss || running !== e.running) begin
      fails++;
      $display("FAIL tick_flags: got hits=%0d miss=%0b run=%0b expected hits=%0d miss=%0b run=%0b",
               hits, miss, running, e.hits, e.miss, e.running);
    end
  endtask

  task automatic serve(input bit with_tick);
    @(negedge clk);
    start = 1'b1;
    tick  = with_tick;
    @(negedge clk);
    start = 1'b0;
    tick  = 1'b0;
    if (mst == 0) mst = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    tests++;
    if (x_b !== 8'd128 || y_b !== 8'd128 || running !== 1'b0 || hits !== 8'd0 || miss !== 1'b0) begin
      fails++;
      $display("FAIL reset: got (%0d,%0d) run=%0b hits=%0d miss=%0b expected (128,128) 0 0 0",
               x_b, y_b, running, hits, miss);
    end
  endtask

  task automatic test_idle_tick();
    repeat (2) do_tick();
    tests++;
    if (x_b !== 8'd128 || y_b !== 8'd128) begin
      fails++;
      $display("FAIL idle_tick: got (%0d,%0d) expected (128,128)", x_b, y_b);
    end
  endtask

  task automatic test_serve();
    serve(1'b1);
    tests++;
    if (running !== 1'b1 || x_b !== 8'd128 || y_b !== 8'd128) begin
      fails++;
      $display("FAIL serve_with_tick: got run=%0b (%0d,%0d) expected run=1 (128,128)",
               running, x_b, y_b);
    end
    do_tick();
    tests++;
    if (x_b !== 8'd130 || y_b !== 8'd130) begin
      fails++;
      $display("FAIL serve_step: got (%0d,%0d) expected (130,130)", x_b, y_b);
    end
  endtask

  task automatic test_top_wall_corner();
    repeat (54) do_tick();
    tests++;
    if (y_b !== 8'd238) begin
      fails++;
      $display("FAIL pre_wall: got y=%0d expected 238", y_b);
    end
    do_tick();
    tests++;
    if (x_b !== 8'd239 || y_b !== 8'd239) begin
      fails++;
      $display("FAIL corner: got (%0d,%0d) expected (239,239)", x_b, y_b);
    end
    do_tick();
    tests++;
    if (x_b !== 8'd237 || y_b !== 8'd237) begin
      fails++;
      $display("FAIL after_corner: got (%0d,%0d) expected (237,237)", x_b, y_b);
    end
  endtask

  task automatic test_paddle_hit();
    int n = 0;
    y_p = 8'd30;
    while (x_b !== 8'd24 && n < 200) begin
      do_tick();
      n++;
    end
    tests++;
    if (x_b !== 8'd24 || y_b !== 8'd23 || hits !== 8'd1) begin
      fails++;
      $display("FAIL paddle_hit: got (%0d,%0d) hits=%0d expected (24,23) hits=1", x_b, y_b, hits);
    end
  endtask

  task automatic test_miss();
    int n = 0;
    int fx, fy;
    y_p = 8'd250;
    while (miss !== 1'b1 && n < 400) begin
      do_tick();
      n++;
    end
    tests++;
    if (miss !== 1'b1 || running !== 1'b0 || mst != 2) begin
      fails++;
      $display("FAIL miss_seen: got miss=%0b run=%0b expected miss=1 run=0", miss, running);
    end
    fx = mx; fy = my;
    @(negedge clk);
    tests++;
    if (miss !== 1'b0) begin
      fails++;
      $display("FAIL miss_pulse_width: got miss=%0b expected 0", miss);
    end
    repeat (59) do_tick();
    tests++;
    if (x_b !== 8'(fx) || y_b !== 8'(fy) || running !== 1'b0) begin
      fails++;
      $display("FAIL miss_frozen: got (%0d,%0d) run=%0b expected (%0d,%0d) run=0",
               x_b, y_b, running, fx, fy);
    end
    do_tick();
    tests++;
    if (x_b !== 8'd128 || y_b !== 8'd128 || hits !== 8'd1 || running !== 1'b0) begin
      fails++;
      $display("FAIL miss_release: got (%0d,%0d) hits=%0d run=%0b expected (128,128) hits=1 run=0",
               x_b, y_b, hits, running);
    end
  endtask

  task automatic test_back_to_back();
    serve(1'b0);
    model_tick(int'(y_p));
    model_tick(int'(y_p));
    push_expect();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (x_b !== 8'(e.x) || y_b !== 8'(e.y) || running !== e.running) begin
        fails++;
        $display("FAIL back_to_back_model: got (%0d,%0d) run=%0b expected (%0d,%0d) run=%0b",
                 x_b, y_b, running, e.x, e.y, e.running);
      end
    end
    tests++;
    if (x_b !== 8'd132 || y_b !== 8'd124) begin
      fails++;
      $display("FAIL back_to_back: got (%0d,%0d) expected (132,124)", x_b, y_b);
    end
  endtask

  task automatic test_reset_mid_run();
    repeat (10) do_tick();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
    tests++;
    if (x_b !== 8'd128 || y_b !== 8'd128 || running !== 1'b0 || hits !== 8'd0 || miss !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: got (%0d,%0d) run=%0b hits=%0d miss=%0b expected (128,128) 0 0 0",
               x_b, y_b, running, hits, miss);
    end
    @(negedge clk);
    tests++;
    if (miss !== 1'b0 || x_b !== 8'd128) begin
      fails++;
      $display("FAIL reset_no_miss: got miss=%0b x=%0d expected miss=0 x=128", miss, x_b);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_tick();
    test_serve();
    test_top_wall_corner();
    test_paddle_hit();
    test_miss();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
